// File: rtl/parity_arbiter_if.sv
// Requester/consumer bundle for parity_arbiter: nibble requests in, grants
// and registered parity results out.
interface parity_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CNTW = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] data;
  logic [NREQ-1:0]   gnt;
  logic              out_valid;
  logic              out_ready;
  logic              out_q;
  logic [IDW-1:0]    out_id;
  logic [3:0]        out_data;
  logic [CNTW-1:0]   err_count;

  // Arbiter side
  modport slave (
    input  req, data, out_ready,
    output gnt, out_valid, out_q, out_id, out_data, err_count
  );

  // Producer/consumer side
  modport master (
    output req, data, out_ready,
    input  gnt, out_valid, out_q, out_id, out_data, err_count
  );
endinterface

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one even-parity evaluator among NREQ nibble
// producers; one registered result slot with a valid/ready output and a
// saturating count of odd-parity results delivered.
module parity_arbiter #(
  parameter int NREQ = 4,
  parameter int CNTW = 8
) (
  input logic            clk,
  input logic            reset,
  parity_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW:0]    NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [CNTW-1:0] ERR_MAX = '1;

  typedef enum logic {IDLE, HOLD} state_t;

  typedef struct packed {
    logic           q;
    logic [IDW-1:0] id;
    logic [3:0]     nib;
  } res_t;

  state_t                 state, state_nx;
  res_t                   res;
  logic [IDW-1:0]         ptr, win;
  logic [IDW:0]           idx;
  logic [NREQ-1:0][3:0]   nib;
  logic [CNTW-1:0]        err;
  logic                   any_req, accept, capture, deliver;

  assign nib     = bus.data;
  assign any_req = |bus.req;
  assign accept  = (state == IDLE) | ((state == HOLD) & bus.out_ready);
  // Reset gates the grant combinationally so it drops the moment reset rises.
  assign capture = accept & any_req & ~reset;
  assign deliver = (state == HOLD) & bus.out_ready;

  // Winner: first set request searching upward from ptr+1 with wrap. The loop
  // runs farthest-first so the nearest hit overwrites earlier ones.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (bus.req[idx[IDW-1:0]]) win = idx[IDW-1:0];
    end
  end

  assign bus.gnt = capture ? (NREQ'(1) << win) : '0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: fill from IDLE on any request; drain to IDLE when the held
  // result is taken and nothing replaces it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (any_req) state_nx = HOLD;
      HOLD: if (bus.out_ready && !any_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result slot and round-robin pointer, both updated only on a capture edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res <= '0;
      ptr <= IDW'(NREQ-1);
    end else if (capture) begin
      res <= '{q: ~^nib[win], id: win, nib: nib[win]};
      ptr <= win;
    end
  end

  // Saturating count of odd-parity results as they leave the slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  err <= '0;
    else if (deliver && !res.q && err != ERR_MAX) err <= err + CNTW'(1);
  end

  assign bus.out_valid = (state == HOLD);
  assign bus.out_q     = res.q;
  assign bus.out_id    = res.id;
  assign bus.out_data  = res.nib;
  assign bus.err_count = err;
endmodule

// File: tb/tb_parity_arbiter.sv
// Directed bench for parity_arbiter: scoreboard of expected results pushed at
// grant time and popped when the result appears in the output slot.
module tb_parity_arbiter;
  logic clk = 1'b0;
  logic reset;

  parity_arbiter_if #(.NREQ(4), .CNTW(8)) bus ();
  parity_arbiter_if #(.NREQ(4), .CNTW(2)) bus2 ();

  parity_arbiter #(.NREQ(4), .CNTW(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
  parity_arbiter #(.NREQ(4), .CNTW(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  typedef struct {
    logic       q;
    logic [1:0] id;
    logic [3:0] nib;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_err = 0;
  logic pend_v = 1'b0;
  logic pend_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected parity from a ones count, independent of any xor reduction
  function automatic logic even_ones(input logic [3:0] n);
    return ($countones(n) % 2) == 0;
  endfunction

  task automatic push(input logic [1:0] id, input logic [3:0] n);
    exp_t e;
    e.q = even_ones(n); e.id = id; e.nib = n;
    sb.push_back(e);
  endtask

  // Advance one clock; a result on display with ready high leaves on this edge
  task automatic tick();
    if (pend_v && bus.out_ready) begin
      if (!pend_q && exp_err < 255) exp_err++;
      pend_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s: scoreboard empty, got id %0d data %0h", tag, bus.out_id, bus.out_data);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(bus.out_valid), 32'(1));
      check({tag, "_id"},    32'(bus.out_id),    32'(e.id));
      check({tag, "_data"},  32'(bus.out_data),  32'(e.nib));
      check({tag, "_q"},     32'(bus.out_q),     32'(e.q));
      pend_v = 1'b1;
      pend_q = e.q;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0; bus.out_ready = 1'b0;
    sb.delete(); pend_v = 1'b0; exp_err = 0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] rr;
    reset = 1'b1;
    bus.req = '0;  bus.data = '0;  bus.out_ready = 1'b0;
    bus2.req = '0; bus2.data = '0; bus2.out_ready = 1'b0;
    tick(); tick();

    // Reset values; grant held off even with requests and ready high
    bus.req = 4'hF; bus.out_ready = 1'b1; #1;
    check("rst_gnt",   32'(bus.gnt),       0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_q",     32'(bus.out_q),     0);
    check("rst_id",    32'(bus.out_id),    0);
    check("rst_data",  32'(bus.out_data),  0);
    check("rst_err",   32'(bus.err_count), 0);
    bus.req = '0;
    reset = 1'b0;

    // Single requester
    bus.req = 4'b0100; bus.data[11:8] = 4'b1011; bus.out_ready = 1'b1; #1;
    check("t1_gnt", 32'(bus.gnt), 32'h4);
    push(2'd2, 4'b1011);
    tick();
    bus.req = '0;
    check_out("t1");
    tick();
    check("t1_err",   32'(bus.err_count), 32'(exp_err));
    check("t1_err1",  32'(bus.err_count), 1);
    check("t1_valid", 32'(bus.out_valid), 0);

    // Exhaustive parity on requester 0, back to back
    do_reset();
    bus.out_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      bus.req = 4'b0001; bus.data[3:0] = 4'(v); #1;
      check("t2_gnt", 32'(bus.gnt), 1);
      push(2'd0, 4'(v));
      tick();
      check_out("t2");
    end
    bus.req = '0;
    tick();
    check("t2_err",   32'(bus.err_count), 8);
    check("t2_valid", 32'(bus.out_valid), 0);

    // Round robin with all requests held
    do_reset();
    rr = 16'hC7A1;
    bus.data = rr; bus.req = 4'hF; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t3_gnt", 32'(bus.gnt), 32'(1) << (i % 4));
      push(2'(i % 4), rr[4*(i%4) +: 4]);
      tick();
      check_out("t3");
    end

    // Backpressure: capture requester 1, stall, then handshake + next grant
    bus.req = 4'b0010; #1;
    check("t4_gnt1", 32'(bus.gnt), 32'h2);
    push(2'd1, 4'hA);
    tick();
    check_out("t4_cap");
    bus.out_ready = 1'b0; bus.req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_stall_gnt",   32'(bus.gnt),       0);
      check("t4_stall_valid", 32'(bus.out_valid), 1);
      check("t4_stall_id",    32'(bus.out_id),    1);
      check("t4_stall_data",  32'(bus.out_data),  32'hA);
      tick();
    end
    bus.out_ready = 1'b1; #1;
    check("t4_gnt2", 32'(bus.gnt), 32'h4);
    push(2'd2, 4'h7);
    tick();
    check_out("t4_next");
    bus.req = '0;
    tick();
    check("t4_err", 32'(bus.err_count), 32'(exp_err));

    // Reset mid-operation with a result held
    do_reset();
    bus.req = 4'b0001; bus.data = 16'h0071; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      push(2'd0, 4'b0001);
      tick();
      check_out("t6_fill");
    end
    bus.out_ready = 1'b0; bus.req = '0; #1;
    check("t6_err2",   32'(bus.err_count), 2);
    check("t6_valid1", 32'(bus.out_valid), 1);
    bus.req = 4'b1010; bus.out_ready = 1'b1; #1;
    check("t6_gnt_pre", 32'(bus.gnt), 32'h2);
    reset = 1'b1;
    sb.delete(); pend_v = 1'b0; exp_err = 0;
    #1;
    check("t6_valid0", 32'(bus.out_valid), 0);
    check("t6_err0",   32'(bus.err_count), 0);
    check("t6_gnt0",   32'(bus.gnt),       0);
    check("t6_id0",    32'(bus.out_id),    0);
    tick(); tick();
    reset = 1'b0; #1;
    check("t6_gnt_post", 32'(bus.gnt), 32'h2);
    push(2'd1, 4'b0111);
    tick();
    check_out("t6_after");
    bus.req = '0;
    tick();

    // Saturation on the narrow counter
    check("t5_err_init", 32'(bus2.err_count), 0);
    bus2.req = 4'b0001; bus2.data = 16'h0001; bus2.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 5) bus2.req = '0;
      if (i >= 1) check("t5_err", 32'(bus2.err_count), (i < 3) ? 32'(i) : 32'(3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
